// File: rtl/gemm_tile_sched.sv
// gemm_tile_sched
//   Sequencer for the bit-serial distributed-arithmetic GEMM engine.
//   For each output tile it walks K: it fetches operand tiles, runs the
//   engine for M*DATA_WIDTH_A cycles per K-tile (bias only on K-tile 0),
//   captures one result per row CAP_LAT cycles after the row's last bit,
//   accumulates across K-tiles, then streams the finished rows out.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   start, cfg_*_tiles        job start and tile counts (0 treated as 1)
//   busy, done                job status, done is a one-cycle pulse
//   op_req, op_*_tile         operand fetch request and tile indices
//   op_valid                  operands presented to the engine
//   gen_done, bias_en         engine advance enable and bias select
//   eng_out                   engine result, N lanes, lane 0 in the LSBs
//   res_valid/res_ready       result row handshake
//   res_data, res_row,        accumulated row, global row index,
//   res_col_tile              column-tile index
//
// Optional: define GEMM_TILE_SCHED_PERF_EN to add perf_run_cycles and
//   perf_stall_cycles (32-bit, saturating, cleared at start and reset).
module gemm_tile_sched #(
  parameter int DATA_WIDTH_A      = 8,
  parameter int DATA_WIDTH_output = 8,
  parameter int M                 = 2,
  parameter int N                 = 4,
  parameter int ACC_WIDTH         = 24,
  parameter int CAP_LAT           = 1,
  parameter int CNT_W             = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_W-1:0]               cfg_row_tiles,
  input  logic [CNT_W-1:0]               cfg_col_tiles,
  input  logic [CNT_W-1:0]               cfg_k_tiles,
  output logic                           busy,
  output logic                           done,
  output logic                           op_req,
  output logic [CNT_W-1:0]               op_row_tile,
  output logic [CNT_W-1:0]               op_col_tile,
  output logic [CNT_W-1:0]               op_k_tile,
  input  logic                           op_valid,
  output logic                           gen_done,
  output logic                           bias_en,
  input  logic [N*DATA_WIDTH_output-1:0] eng_out,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [N*ACC_WIDTH-1:0]         res_data,
  output logic [CNT_W-1:0]               res_row,
  output logic [CNT_W-1:0]               res_col_tile
`ifdef GEMM_TILE_SCHED_PERF_EN
  ,
  output logic [31:0]                    perf_run_cycles,
  output logic [31:0]                    perf_stall_cycles
`endif
);

  localparam int BIT_W = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
  localparam int M_W   = (M > 1) ? $clog2(M) : 1;
  localparam int FL_W  = $clog2(CAP_LAT + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH_A - 1);
  localparam logic [M_W-1:0]   M_LAST   = M_W'(M - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(CAP_LAT - 1);
  localparam logic [CNT_W-1:0] M_CNT    = CNT_W'(M);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;

  function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  state_t                  r_state;
  logic [CNT_W-1:0]        r_row_last, r_col_last, r_k_last;
  logic [CNT_W-1:0]        r_row_tile, r_col_tile, r_k_tile;
  logic [BIT_W-1:0]        r_bit;
  logic [M_W-1:0]          r_m, r_drain_m;
  logic [FL_W-1:0]         r_flush_cnt;
  logic                    r_busy, r_done, r_op_req, r_gen_done, r_bias_en, r_res_valid;
  logic [N*ACC_WIDTH-1:0]  r_res_data;
  logic [CNT_W-1:0]        r_res_row, r_res_col_tile;
  logic [CAP_LAT-1:0]      r_cap_v;
  logic [M_W-1:0]          r_cap_m [CAP_LAT];
  logic signed [ACC_WIDTH-1:0] r_acc [M][N];

  logic                        w_strobe;
  logic signed [ACC_WIDTH-1:0] w_sext [N];

  // Last bit cycle of a row: its engine result is valid CAP_LAT cycles later.
  assign w_strobe = (r_state == S_RUN) && (r_bit == BIT_LAST);

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      w_sext[n] = ACC_WIDTH'($signed(eng_out[n*DATA_WIDTH_output +: DATA_WIDTH_output]));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_row_last     <= '0;
      r_col_last     <= '0;
      r_k_last       <= '0;
      r_row_tile     <= '0;
      r_col_tile     <= '0;
      r_k_tile       <= '0;
      r_bit          <= '0;
      r_m            <= '0;
      r_drain_m      <= '0;
      r_flush_cnt    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_op_req       <= 1'b0;
      r_gen_done     <= 1'b0;
      r_bias_en      <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_res_row      <= '0;
      r_res_col_tile <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row_last <= last_of(cfg_row_tiles);
            r_col_last <= last_of(cfg_col_tiles);
            r_k_last   <= last_of(cfg_k_tiles);
            r_row_tile <= '0;
            r_col_tile <= '0;
            r_k_tile   <= '0;
            r_busy     <= 1'b1;
            r_op_req   <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (op_valid) begin
            r_op_req   <= 1'b0;
            r_gen_done <= 1'b1;
            r_bias_en  <= (r_k_tile == '0);
            r_bit      <= '0;
            r_m        <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_bit == BIT_LAST) begin
            r_bit <= '0;
            if (r_m == M_LAST) begin
              r_m         <= '0;
              r_gen_done  <= 1'b0;
              r_bias_en   <= 1'b0;
              r_flush_cnt <= '0;
              r_state     <= S_FLUSH;
            end else begin
              r_m <= r_m + M_W'(1);
            end
          end else begin
            r_bit <= r_bit + BIT_W'(1);
          end
        end
        S_FLUSH: begin
          // The last row is captured on the same edge that leaves FLUSH.
          if (r_flush_cnt == FL_LAST) begin
            r_flush_cnt <= '0;
            if (r_k_tile == r_k_last) begin
              r_drain_m <= '0;
              r_state   <= S_DRAIN;
            end else begin
              r_k_tile <= r_k_tile + CNT_W'(1);
              r_op_req <= 1'b1;
              r_state  <= S_LOAD;
            end
          end else begin
            r_flush_cnt <= r_flush_cnt + FL_W'(1);
          end
        end
        S_DRAIN: begin
          // Load a row while res_valid is low; drop valid only after a handshake.
          if (!r_res_valid) begin
            r_res_valid <= 1'b1;
            for (int n = 0; n < N; n++) begin
              r_res_data[n*ACC_WIDTH +: ACC_WIDTH] <= r_acc[r_drain_m][n];
            end
            r_res_row      <= r_row_tile * M_CNT + CNT_W'(r_drain_m);
            r_res_col_tile <= r_col_tile;
          end else if (res_ready) begin
            r_res_valid <= 1'b0;
            if (r_drain_m == M_LAST) begin
              r_drain_m <= '0;
              r_k_tile  <= '0;
              if (r_col_tile == r_col_last) begin
                r_col_tile <= '0;
                if (r_row_tile == r_row_last) begin
                  r_row_tile <= '0;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= S_DONE;
                end else begin
                  r_row_tile <= r_row_tile + CNT_W'(1);
                  r_op_req   <= 1'b1;
                  r_state    <= S_LOAD;
                end
              end else begin
                r_col_tile <= r_col_tile + CNT_W'(1);
                r_op_req   <= 1'b1;
                r_state    <= S_LOAD;
              end
            end else begin
              r_drain_m <= r_drain_m + M_W'(1);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture pipeline and per-row accumulators.
  // NOTE: the accumulator array is reset explicitly so a job after reset
  // never sees partial sums from an aborted one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cap_v <= '0;
      for (int i = 0; i < CAP_LAT; i++) r_cap_m[i] <= '0;
      for (int m = 0; m < M; m++) begin
        for (int n = 0; n < N; n++) r_acc[m][n] <= '0;
      end
    end else begin
      r_cap_v[0] <= w_strobe;
      r_cap_m[0] <= r_m;
      for (int i = 1; i < CAP_LAT; i++) begin
        r_cap_v[i] <= r_cap_v[i-1];
        r_cap_m[i] <= r_cap_m[i-1];
      end
      if (r_cap_v[CAP_LAT-1]) begin
        for (int n = 0; n < N; n++) begin
          if (r_k_tile == '0) r_acc[r_cap_m[CAP_LAT-1]][n] <= w_sext[n];
          else r_acc[r_cap_m[CAP_LAT-1]][n] <= r_acc[r_cap_m[CAP_LAT-1]][n] + w_sext[n];
        end
      end
    end
  end

`ifdef GEMM_TILE_SCHED_PERF_EN
  logic [31:0] r_perf_run, r_perf_stall;
  logic        w_stall;
  assign w_stall = ((r_state == S_LOAD) && !op_valid) ||
                   ((r_state == S_DRAIN) && r_res_valid && !res_ready);

  always_ff @(posedge clk) begin
    if (!rst || ((r_state == S_IDLE) && start)) begin
      r_perf_run   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_gen_done && (r_perf_run != '1)) r_perf_run <= r_perf_run + 32'd1;
      if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_run_cycles   = r_perf_run;
  assign perf_stall_cycles = r_perf_stall;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign op_req       = r_op_req;
  assign op_row_tile  = r_row_tile;
  assign op_col_tile  = r_col_tile;
  assign op_k_tile    = r_k_tile;
  assign gen_done     = r_gen_done;
  assign bias_en      = r_bias_en;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_row      = r_res_row;
  assign res_col_tile = r_res_col_tile;

endmodule

// File: tb/tb_gemm_tile_sched.sv
// Randomized bench for gemm_tile_sched with a behavioural engine and a
// reference model: every K-tile burst gets fresh per-row lane values, the
// model sums them per output tile and queues the expected result rows.
module tb_gemm_tile_sched;
  localparam int DW = 8, MR = 2, NC = 4, AW = 24, OW = 8, CL = 1, CW = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [CW-1:0] cfg_row_tiles = '0, cfg_col_tiles = '0, cfg_k_tiles = '0;
  logic op_valid = 1'b0, res_ready = 1'b0;
  logic [NC*OW-1:0] eng_out = '0;
  logic busy, done, op_req, gen_done, bias_en, res_valid;
  logic [CW-1:0] op_row_tile, op_col_tile, op_k_tile, res_row, res_col_tile;
  logic [NC*AW-1:0] res_data;
`ifdef GEMM_TILE_SCHED_PERF_EN
  logic [31:0] perf_run_cycles, perf_stall_cycles;
`endif

  gemm_tile_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_row_tiles(cfg_row_tiles), .cfg_col_tiles(cfg_col_tiles), .cfg_k_tiles(cfg_k_tiles),
    .busy(busy), .done(done), .op_req(op_req),
    .op_row_tile(op_row_tile), .op_col_tile(op_col_tile), .op_k_tile(op_k_tile),
    .op_valid(op_valid), .gen_done(gen_done), .bias_en(bias_en), .eng_out(eng_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col_tile(res_col_tile)
`ifdef GEMM_TILE_SCHED_PERF_EN
    , .perf_run_cycles(perf_run_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [NC*AW-1:0] data;
    logic [CW-1:0]    row;
    logic [CW-1:0]    col;
  } res_t;

  // Job context, written by the main sequence before each start.
  int job_rows = 1, job_cols = 1, job_ks = 1;
  int op_delay = 0, val_mode = 0;
  bit rand_ready = 1'b0, stall_req = 1'b0;

  // Reference model and monitor state.
  int gd_cnt = 0, bursts = 0, op_wait = 0, stall_cnt = 0, n_done = 0;
  int vals [MR][NC];
  logic [AW-1:0] macc [MR][NC];
  bit exp_bias = 1'b0, bias_bad = 1'b0, prev_op_req = 1'b0, idx_bad = 1'b0, gd_load = 1'b0;
  bit held = 1'b0;
  res_t held_r;
  logic [3*CW-1:0] op_idx0;
  bit line_v [CL+1];
  int line_r [CL+1];
  res_t exp_q [$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        gd_cnt = 0; bursts = 0; held = 1'b0; prev_op_req = 1'b0; stall_cnt = 0; n_done = 0;
        exp_q.delete();
        for (int i = 0; i <= CL; i++) line_v[i] = 1'b0;
        op_valid = 1'b0; res_ready = 1'b0; eng_out = '0;
      end else begin
        bit strobe;
        int srow;
        strobe = 1'b0; srow = 0;
        // Behavioural engine and K-tile accumulation model.
        if (gen_done) begin
          if (gd_cnt == 0) begin
            int k, t;
            k = bursts % job_ks;
            t = bursts / job_ks;
            for (int m = 0; m < MR; m++) begin
              for (int n = 0; n < NC; n++) begin
                if (val_mode == 1) vals[m][n] = (m == 0) ? 5 : -3;
                else if (val_mode == 2) vals[m][n] = 100;
                else vals[m][n] = int'($urandom_range(255)) - 128;
                if (k == 0) macc[m][n] = AW'(vals[m][n]);
                else macc[m][n] = macc[m][n] + AW'(vals[m][n]);
              end
            end
            if (k == job_ks - 1) begin
              for (int m = 0; m < MR; m++) begin
                res_t e;
                for (int n = 0; n < NC; n++) e.data[n*AW +: AW] = macc[m][n];
                e.row = CW'((t / job_cols) * MR + m);
                e.col = CW'(t % job_cols);
                exp_q.push_back(e);
              end
            end
            exp_bias = (k == 0);
            bias_bad = 1'b0;
            bursts++;
          end
          if (bias_en !== exp_bias) bias_bad = 1'b1;
          if (gd_cnt % DW == DW - 1) begin
            strobe = 1'b1;
            srow = gd_cnt / DW;
          end
          gd_cnt++;
        end else if (gd_cnt != 0) begin
          check("run_len", 128'(gd_cnt), 128'(MR * DW));
          check("bias_const", 128'(bias_bad), 128'(0));
          gd_cnt = 0;
        end
        for (int i = CL; i > 0; i--) begin
          line_v[i] = line_v[i-1];
          line_r[i] = line_r[i-1];
        end
        line_v[0] = strobe;
        line_r[0] = srow;
        if (line_v[CL]) begin
          for (int n = 0; n < NC; n++) eng_out[n*OW +: OW] = OW'(vals[line_r[CL]][n]);
        end else begin
          eng_out = $urandom;
        end

        // Operand requests: issue order, index stability, no overlap with RUN.
        if (op_req && !prev_op_req) begin
          int t;
          t = bursts / job_ks;
          op_idx0 = {op_row_tile, op_col_tile, op_k_tile};
          check("op_idx", 128'(op_idx0),
                128'({CW'(t / job_cols), CW'(t % job_cols), CW'(bursts % job_ks)}));
          check("op_after_drain", 128'(exp_q.size()), 128'(0));
          idx_bad = 1'b0; gd_load = 1'b0; op_wait = 0;
        end
        if (op_req) begin
          if ({op_row_tile, op_col_tile, op_k_tile} !== op_idx0) idx_bad = 1'b1;
          if (gen_done) gd_load = 1'b1;
          op_wait++;
        end
        if (!op_req && prev_op_req) begin
          check("op_stable", 128'(idx_bad), 128'(0));
          check("gd_in_load", 128'(gd_load), 128'(0));
        end
        prev_op_req = op_req;
        op_valid = (op_delay == 0) ? 1'b1 : (op_req && (op_wait > op_delay));

        // Result stream.
        if (held) begin
          check("hold_valid", 128'(res_valid), 128'(1));
          check("hold_data", {res_data, res_row, res_col_tile}, {held_r.data, held_r.row, held_r.col});
          held = 1'b0;
        end
        if (stall_req && res_valid) begin
          stall_cnt = 10;
          stall_req = 1'b0;
        end
        if (stall_cnt > 0) begin
          res_ready = 1'b0;
          stall_cnt--;
        end else begin
          res_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            check("res_unexpected", 128'(1), 128'(0));
          end else begin
            res_t e;
            e = exp_q.pop_front();
            check("res_data", 128'(res_data), 128'(e.data));
            check("res_row", 128'(res_row), 128'(e.row));
            check("res_col", 128'(res_col_tile), 128'(e.col));
          end
        end else if (res_valid) begin
          held = 1'b1;
          held_r.data = res_data; held_r.row = res_row; held_r.col = res_col_tile;
        end
        if (done) n_done++;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_op_req"}, 128'(op_req), 128'(0));
    check({tag, "_op_idx"}, 128'({op_row_tile, op_col_tile, op_k_tile}), 128'(0));
    check({tag, "_gen_done"}, 128'(gen_done), 128'(0));
    check({tag, "_bias_en"}, 128'(bias_en), 128'(0));
    check({tag, "_res_valid"}, 128'(res_valid), 128'(0));
    check({tag, "_res"}, {res_data, res_row, res_col_tile}, 128'(0));
  endtask

  task automatic start_job(input int r, input int c, input int k, input int dly,
                           input bit rr, input int vm, input bit st);
    job_rows = (r == 0) ? 1 : r;
    job_cols = (c == 0) ? 1 : c;
    job_ks   = (k == 0) ? 1 : k;
    op_delay = dly; rand_ready = rr; val_mode = vm; stall_req = st;
    bursts = 0; n_done = 0;
    exp_q.delete();
    @(posedge clk); #2;
    cfg_row_tiles = CW'(r); cfg_col_tiles = CW'(c); cfg_k_tiles = CW'(k);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'(1));
    cfg_row_tiles = CW'($urandom_range(1, 9));
    cfg_col_tiles = CW'($urandom_range(1, 9));
    cfg_k_tiles   = CW'($urandom_range(1, 9));
  endtask

  task automatic finish_job();
    int cyc;
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("done_seen", 128'(done), 128'(1));
    check("busy_at_done", 128'(busy), 128'(0));
    repeat (4) @(posedge clk);
    #2;
    check("done_once", 128'(n_done), 128'(1));
    check("rows_left", 128'(exp_q.size()), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));
  endtask

  task automatic run_job(input int r, input int c, input int k, input int dly,
                         input bit rr, input int vm, input bit st);
    start_job(r, c, k, dly, rr, vm, st);
    finish_job();
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    rst = 1'b1;

    run_job(1, 1, 1, 0, 1'b0, 1, 1'b0);   // single tile, rows 5 and -3
    run_job(1, 1, 3, 0, 1'b0, 2, 1'b0);   // three K-tiles of 100
    run_job(2, 2, 0, 0, 1'b1, 0, 1'b0);   // ordering, k count 0 treated as 1
    run_job(1, 2, 2, 0, 1'b0, 0, 1'b1);   // 10-cycle backpressure in DRAIN
    run_job(1, 1, 2, 7, 1'b0, 0, 1'b0);   // operands 7 cycles late

    // Reset during RUN at bit 3 of row 1.
    start_job(1, 1, 1, 0, 1'b0, 0, 1'b0);
    cyc = 0;
    while (gen_done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("rst_run_seen", 128'(gen_done), 128'(1));
    repeat (DW + 3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    check_zero("rst_mid");
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check("rst_no_done", 128'(n_done), 128'(0));
    check("rst_idle", 128'(busy), 128'(0));
    run_job(1, 1, 1, 0, 1'b0, 0, 1'b0);

    for (int j = 0; j < 4; j++) begin
      run_job(int'($urandom_range(1, 2)), int'($urandom_range(1, 2)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'b1, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_tile_sched.md
Name: gemm_tile_sched

Overview:
- Sequencer for the bit-serial distributed-arithmetic GEMM engine.
- Per output tile, it walks the K dimension:
  - requests operand tiles from the A/B/bias buffers;
  - drives the engine's `gen_done` for exactly M×DATA_WIDTH_A cycles per K-tile;
  - drives `bias_en` high only on the first K-tile;
  - captures each row result and accumulates partial sums across K-tiles.
- Finished rows are streamed out over a valid/ready interface.
- Sits between the layer controller (start/done, tile counts) and the engine plus its operand buffers.

Parameters:
- DATA_WIDTH_A, 8, A operand bit width; bit-serial pass length per row.
- DATA_WIDTH_output, 8, engine result width per column.
- M, 2, rows per A tile; the engine iterates these internally.
- N, 4, columns per tile.
- ACC_WIDTH, 24, signed accumulator width per column.
- CAP_LAT, 1, cycles from a row's last bit cycle to a valid engine result (1..4).
- CNT_W, 16, width of the tile-count configuration fields.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin a job; sampled in IDLE only
- cfg_row_tiles  in  CNT_W  row-tile count; 0 is treated as 1
- cfg_col_tiles  in  CNT_W  column-tile count; 0 is treated as 1
- cfg_k_tiles  in  CNT_W  K-tile count; 0 is treated as 1
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last row of the last tile is accepted
- op_req  out  1  operand-tile fetch request; held until op_valid
- op_row_tile, op_col_tile, op_k_tile  out  CNT_W each  tile indices; stable while op_req
- op_valid  in  1  requested A/B/bias are presented to the engine and held until the next op_req
- gen_done  out  1  engine advance enable
- bias_en  out  1  engine bias select
- eng_out  in  N*DATA_WIDTH_output  engine final_out, flattened, column 0 in the LSBs
- res_valid  out  1  result row valid
- res_ready  in  1  downstream accept
- res_data  out  N*ACC_WIDTH  accumulated row, flattened
- res_row  out  CNT_W  global row index = row_tile*M + m
- res_col_tile  out  CNT_W  column-tile index of res_data

Behaviour:
- Reset (rst low at a clock edge):
  - state goes to IDLE; all tile, bit and row counters and all accumulators clear;
  - every output goes to 0.
  - Applies from any state, including mid-RUN or mid-DRAIN.
  - The engine is not separately reset; a job started after reset begins at bit 0, row 0.
- States and transitions:
  - IDLE: on start, latch the cfg values (0 forced to 1), clear the indices, go to LOAD.
  - LOAD: op_req=1. On op_valid, go to RUN next cycle.
  - RUN:
    - gen_done=1 for exactly M×DATA_WIDTH_A consecutive cycles;
    - bit counter runs 0..DATA_WIDTH_A-1 and row counter m runs 0..M-1;
    - bias_en = (k_tile==0) for the whole RUN.
    - After the last cycle, go to FLUSH.
  - FLUSH: gen_done=0. Wait until all outstanding captures complete (CAP_LAT cycles).
    - If k_tile < k_tiles-1: increment k_tile, go to LOAD.
    - Otherwise go to DRAIN.
  - DRAIN:
    - present rows m=0..M-1 in order, one per res_valid&&res_ready;
    - after row M-1 is accepted, reset k_tile=0, advance col_tile, wrapping into row_tile;
    - go to LOAD, or to DONE after the last tile.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Capture:
  - A strobe is generated in the RUN cycle with bit==DATA_WIDTH_A-1 for row m.
  - It is delayed CAP_LAT cycles through a shift register; the delayed strobe samples eng_out into row m's accumulator.
  - With CAP_LAT=1, row m is captured during row m+1's bit-0 cycle.
- Arithmetic:
  - eng_out lanes are sign-extended to ACC_WIDTH.
  - On k_tile==0: acc[m][n] = sext. Otherwise acc[m][n] += sext.
  - Two's-complement wrap; no saturation.
- Output handshake:
  - res_data, res_row and res_col_tile are stable while res_valid && !res_ready.
  - res_valid never drops without a handshake.
- Ordering: tile issue order is k innermost, then col, then row.
- Corner cases:
  - start while busy is ignored.
  - cfg changes after start have no effect.
  - gen_done is never high outside RUN, and is never paused mid-RUN; op_valid is only sampled in LOAD.
- Latency:
  - one tile = LOAD wait + M×DATA_WIDTH_A + CAP_LAT + 1 cycles per K-tile;
  - plus ≥ M cycles of DRAIN.

Optional Feature:
- Macro: GEMM_TILE_SCHED_PERF_EN.
- When defined, two 32-bit outputs are added, both cleared at start and at reset, both saturating at all-ones:
  - perf_run_cycles counts cycles with gen_done=1;
  - perf_stall_cycles counts cycles in LOAD with op_valid=0 plus DRAIN cycles with res_valid && !res_ready.
- When undefined, the ports and counters do not exist.
- Functional behaviour is identical either way.

Test Plan:
- Single tile, defaults, cfg all 1, op_valid tied 1, eng_out row0 all lanes 5, row1 all lanes -3:
  - gen_done high exactly 16 consecutive cycles, bias_en high throughout;
  - res rows (0: 5,5,5,5), (1: -3,-3,-3,-3);
  - done pulses once.
- cfg_k_tiles=3, eng_out constant 100 every lane:
  - three RUN bursts of 16 cycles; bias_en high only in the first;
  - every res lane = 300; op_k_tile sequence 0,1,2.
- Ordering, cfg_row_tiles=2, cfg_col_tiles=2, cfg_k_tiles=0:
  - op (row,col,k) sequence (0,0,0),(0,1,0),(1,0,0),(1,1,0);
  - res_row values 0,1,0,1,2,3,2,3.
- Backpressure: res_ready low 10 cycles during DRAIN:
  - res_data and res_row stay constant, res_valid stays high;
  - no op_req is issued until row M-1 is accepted.
- op_valid delayed 7 cycles in LOAD: gen_done stays 0 for those cycles, op indices stay stable, and results are unchanged.
- rst low for one cycle mid-RUN (bit 3, row 1):
  - the next cycle shows all outputs 0 and the state in IDLE;
  - a subsequent start completes a single tile correctly with no extra done pulse.
